// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_pkg
// Description : Shared types and constants for the FIFO read-side drain stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_rd_pkg;

    // Occupancy of the two-entry output buffer
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    localparam int CNT_W         = 16;
    localparam int BEAT_W        = 8;
    localparam int BURST_LEN_DEF = 4;

endpackage
`default_nettype wire

// File: rtl/rd_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : rd_skid_buf
// Description : Two-entry in-order output buffer with occupancy FSM.
//               head_o always presents the oldest stored word.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_SIZE = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [DATA_SIZE-1:0] push_data_i,
    input  logic                 pop_i,
    output logic                 valid_o,
    output logic [DATA_SIZE-1:0] head_o,
    output occ_e                 occ_o
);

    occ_e                 occ_q;
    logic [DATA_SIZE-1:0] head_q;
    logic [DATA_SIZE-1:0] tail_q;

    // Occupancy FSM and storage; head_q is the oldest word, tail_q the next.
    // The upstream credit logic never pushes into a full buffer without a pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q  <= EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case (occ_q)
                EMPTY: begin
                    if (push_i) begin
                        head_q <= push_data_i;
                        occ_q  <= ONE;
                    end
                end
                ONE: begin
                    case ({push_i, pop_i})
                        2'b10: begin
                            tail_q <= push_data_i;
                            occ_q  <= TWO;
                        end
                        2'b01: occ_q  <= EMPTY;
                        2'b11: head_q <= push_data_i;
                        default: ;
                    endcase
                end
                TWO: begin
                    case ({push_i, pop_i})
                        2'b01: begin
                            head_q <= tail_q;
                            occ_q  <= ONE;
                        end
                        2'b11: begin
                            head_q <= tail_q;
                            tail_q <= push_data_i;
                        end
                        default: ;
                    endcase
                end
                default: occ_q <= EMPTY;
            endcase
        end
    end

    assign valid_o = (occ_q != EMPTY);
    assign head_o  = head_q;
    assign occ_o   = occ_q;

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_stream
// Description : Drains an async FIFO read port into a valid/ready stream,
//               absorbing the FIFO's one-cycle read latency, framing bursts
//               of BURST_LEN words and counting delivered words and bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DATA_SIZE = 12,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 rEmpty,
    input  logic [DATA_SIZE-1:0] rData,
    output logic                 rinc,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_SIZE-1:0] m_data,
    output logic                 m_sop,
    output logic                 m_eop,
    output logic [CNT_W-1:0]     word_cnt,
    output logic [CNT_W-1:0]     burst_cnt
);

    localparam logic [BEAT_W-1:0] c_LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    logic              pend_q;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]  word_q, word_d;
    logic [CNT_W-1:0]  burst_q, burst_d;

    occ_e              w_occ;
    logic [1:0]        w_occ_bits;
    logic              w_pop;
    logic [2:0]        w_fill;

    assign w_pop      = m_valid & m_ready;
    assign w_occ_bits = w_occ;

    // Credit check: buffered words plus the one in flight, after this cycle's
    // pop, must leave room for one more; a pop reopens rinc in the same cycle.
    assign w_fill = {1'b0, w_occ_bits} + {2'b00, pend_q} - {2'b00, w_pop};
    assign rinc   = ~rEmpty & (w_fill < 3'd2);

    rd_skid_buf #(
        .DATA_SIZE (DATA_SIZE)
    ) u_buf (
        .clk_i       (rclk),
        .rst_ni      (rrst),
        .push_i      (pend_q),
        .push_data_i (rData),
        .pop_i       (w_pop),
        .valid_o     (m_valid),
        .head_o      (m_data),
        .occ_o       (w_occ)
    );

    assign m_sop = (beat_q == '0);
    assign m_eop = (beat_q == c_LAST_BEAT);

    // Next-state for the burst position and the wrapping statistics counters
    always_comb begin
        beat_d  = beat_q;
        word_d  = word_q + CNT_W'(w_pop);
        burst_d = burst_q + CNT_W'(w_pop & m_eop);
        if (w_pop) begin
            beat_d = m_eop ? '0 : beat_q + 1'b1;
        end
    end

    // In-flight flag tracks the FIFO's registered read; counters update on pop
    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            pend_q  <= 1'b0;
            beat_q  <= '0;
            word_q  <= '0;
            burst_q <= '0;
        end else begin
            pend_q  <= rinc;
            beat_q  <= beat_d;
            word_q  <= word_d;
            burst_q <= burst_d;
        end
    end

    assign word_cnt  = word_q;
    assign burst_cnt = burst_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_stream
// Description : Scoreboard bench for fifo_rd_stream with a behavioural
//               async-FIFO read port model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

    localparam int DW    = 12;
    localparam int BL    = 4;
    localparam int MEMSZ = 1024;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sop;
        logic          eop;
    } exp_t;

    logic          rclk = 1'b0;
    logic          rrst = 1'b0;
    logic          rEmpty;
    logic [DW-1:0] rData;
    logic          rinc;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_sop;
    logic          m_eop;
    logic [15:0]   word_cnt;
    logic [15:0]   burst_cnt;

    always #5 rclk = ~rclk;

    fifo_rd_stream #(
        .DATA_SIZE (DW),
        .BURST_LEN (BL)
    ) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rEmpty    (rEmpty),
        .rData     (rData),
        .rinc      (rinc),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_sop     (m_sop),
        .m_eop     (m_eop),
        .word_cnt  (word_cnt),
        .burst_cnt (burst_cnt)
    );

    // FIFO read-port model: registered empty flag, one-cycle read latency
    logic [DW-1:0] mem [0:MEMSZ-1];
    int unsigned   wr_ptr = 0;
    int unsigned   rd_ptr = 0;
    logic          gap    = 1'b0;

    always @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            rd_ptr <= wr_ptr;
            rEmpty <= 1'b1;
            rData  <= '0;
        end else if (rinc) begin
            rData  <= mem[rd_ptr % MEMSZ];
            rd_ptr <= rd_ptr + 1;
            rEmpty <= (wr_ptr == rd_ptr + 1) || gap;
        end else begin
            rEmpty <= (wr_ptr == rd_ptr) || gap;
        end
    end

    exp_t exp_q[$];
    int   n_vec    = 0;
    int   n_miss   = 0;
    int   pos      = 0;
    int   rinc_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] d, input logic sop, input logic eop);
        int guard = 0;
        while ((wr_ptr - rd_ptr) >= MEMSZ - 8 && guard < 10000) begin
            @(posedge rclk); #1;
            guard++;
        end
        if (guard >= 10000) begin
            n_vec++;
            n_miss++;
            $display("FAIL fifo_space_timeout: fill %0d, required below %0d", wr_ptr - rd_ptr, MEMSZ - 8);
        end
        mem[wr_ptr % MEMSZ] = d;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back({d, sop, eop});
    endtask

    task automatic push_auto(input logic [DW-1:0] d);
        push_word(d, (pos % BL) == 0, (pos % BL) == BL - 1);
        pos++;
    endtask

    task automatic do_reset(input bit chk);
        @(posedge rclk); #1;
        rrst    = 1'b0;
        m_ready = 1'b0;
        gap     = 1'b0;
        repeat (3) @(posedge rclk);
        #1;
        exp_q.delete();
        pos      = 0;
        rinc_cnt = 0;
        if (chk) begin
            check("rst_m_valid", m_valid, 0);
            check("rst_m_data", m_data, 0);
            check("rst_m_sop", m_sop, 1);
            check("rst_m_eop", m_eop, 0);
            check("rst_word_cnt", word_cnt, 0);
            check("rst_burst_cnt", burst_cnt, 0);
            check("rst_rinc", rinc, 0);
        end
        rrst = 1'b1;
    endtask

    task automatic wait_drain(input int maxc);
        int c = 0;
        while (exp_q.size() != 0 && c < maxc) begin
            @(posedge rclk); #1;
            c++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
        end
        @(posedge rclk); #1;
    endtask

    task automatic wait_valid(input string name);
        int c = 0;
        while (!m_valid && c < 50) begin
            @(negedge rclk);
            c++;
        end
        if (!m_valid) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: m_valid got 0, required 1 within 50 cycles", name);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted word, checks stall hold
    initial begin
        logic          stall_prev;
        logic [DW+1:0] held;
        exp_t          e;
        stall_prev = 1'b0;
        held       = '0;
        forever begin
            @(negedge rclk);
            if (!rrst) begin
                stall_prev = 1'b0;
            end else begin
                if (rinc) rinc_cnt++;
                if (stall_prev)
                    check("stall_hold", {m_valid, m_data, m_sop, m_eop}, {1'b1, held});
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_miss++;
                        $display("FAIL unexpected_word: got %0h, required no word", m_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("word", {m_data, m_sop, m_eop}, e);
                    end
                end
                stall_prev = m_valid && !m_ready;
                held       = {m_data, m_sop, m_eop};
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] t2_d   [8]  = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006, 12'h007, 12'h008};
    logic          t2_sop [8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic          t2_eop [8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic          t3_sop [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic          t3_eop [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic          done = 1'b0;

    initial begin
        int c;
        int cnt;

        // Single word with latency check
        do_reset(1'b1);
        m_ready = 1'b1;
        push_word(12'h0A5, 1'b1, 1'b0);
        c = 0;
        @(negedge rclk);
        while (!rinc && c < 20) begin
            @(negedge rclk);
            c++;
        end
        check("t1_rinc_seen", rinc, 1);
        @(negedge rclk);
        check("t1_valid_t1", m_valid, 0);
        @(negedge rclk);
        check("t1_valid_t2", m_valid, 1);
        wait_drain(50);
        check("t1_word_cnt", word_cnt, 1);
        check("t1_burst_cnt", burst_cnt, 0);
        check("t1_rinc_pulses", rinc_cnt, 1);

        // Two full bursts back to back, no bubbles
        do_reset(1'b0);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_word(t2_d[i], t2_sop[i], t2_eop[i]);
        wait_valid("t2_first_valid");
        cnt = 0;
        repeat (8) begin
            if (m_valid) cnt++;
            @(negedge rclk);
        end
        check("t2_valid_cycles", cnt, 8);
        check("t2_valid_after", m_valid, 0);
        wait_drain(50);
        check("t2_word_cnt", word_cnt, 8);
        check("t2_burst_cnt", burst_cnt, 2);

        // Backpressure with 10 words queued, then release
        do_reset(1'b0);
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) push_word(12'h100 + 12'(i), t3_sop[i], t3_eop[i]);
        repeat (12) @(posedge rclk);
        #1;
        check("t3_rinc_pulses", rinc_cnt, 2);
        check("t3_valid_stall", m_valid, 1);
        check("t3_head", m_data, 12'h100);
        m_ready = 1'b1;
        @(negedge rclk);
        check("t3_restart_rinc", rinc, 1);
        wait_drain(100);
        check("t3_word_cnt", word_cnt, 10);
        check("t3_burst_cnt", burst_cnt, 2);

        // Random ready and FIFO empty gaps over 1000 words
        do_reset(1'b0);
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    push_auto(12'(i * 7 + 3));
                    if ($urandom_range(0, 1) == 1) begin
                        @(posedge rclk); #1;
                    end
                    if ($urandom_range(0, 7) == 0) begin
                        gap = 1'b1;
                        repeat ($urandom_range(1, 4)) @(posedge rclk);
                        #1;
                        gap = 1'b0;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge rclk); #1;
                    m_ready = 1'($urandom_range(0, 1));
                end
                m_ready = 1'b1;
            end
        join
        wait_drain(10000);
        check("t4_word_cnt", word_cnt, 1000);
        check("t4_burst_cnt", burst_cnt, 250);

        // Reset mid-stream with a word buffered and one in flight
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_auto(12'h200 + 12'(i));
        @(negedge rclk);
        wait_valid("t5_valid");
        #2;
        rrst = 1'b0;
        #1;
        check("t5_valid_async", m_valid, 0);
        check("t5_word_cnt_async", word_cnt, 0);
        check("t5_burst_cnt_async", burst_cnt, 0);
        exp_q.delete();
        pos = 0;
        repeat (2) @(posedge rclk);
        #1;
        rrst    = 1'b1;
        m_ready = 1'b1;
        push_word(12'h3C3, 1'b1, 1'b0);
        wait_drain(50);
        check("t5_word_cnt", word_cnt, 1);

        // Counter wrap over 65536 words
        do_reset(1'b0);
        m_ready = 1'b1;
        for (int i = 0; i < 65536; i++) push_auto(12'(i));
        wait_drain(5000);
        check("t6_word_cnt_wrap", word_cnt, 0);
        check("t6_burst_cnt", burst_cnt, 16384);
        check("t6_valid_idle", m_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
